// File: rtl/fetch_unit.sv
// fetch_unit: single-clock instruction-fetch stage for the multi-cycle RV32I core.
// Holds the PC, runs a ready-based read handshake with instruction memory,
// captures the returned word and presents it to decode until acknowledged.
// Redirects during an in-flight read cause that read's data to be dropped.
// A misaligned redirect target parks the unit in FAULT until reset.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              INC      = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_ready_i,
  input  logic [31:0]     mem_rdata_i,
  output logic [31:0]     insn_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_inc_o,
  output logic            insn_valid_o,
  input  logic            insn_ack_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            fault_o
);

  localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [31:0]     insn_q, insn_d;
  logic            discard_q, discard_d;
  logic            out_q, out_d;
  logic            run_q, run_d;
  logic            misaligned;

  // Control state and architectural registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      insn_q    <= '0;
      discard_q <= 1'b0;
      out_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      insn_q    <= insn_d;
      discard_q <= discard_d;
      out_q     <= out_d;
      run_q     <= run_d;
    end
  end

  // Address of the outstanding read; only meaningful while out_q is set
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  // Next-state and register updates
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    insn_d     = insn_q;
    discard_d  = discard_q;
    out_d      = out_q;
    addr_d     = addr_q;
    run_d      = 1'b1;
    misaligned = (redirect_pc_i[1:0] != 2'b00);
    case (state_q)
      S_FETCH: begin
        // A freshly issued request freezes its address so a redirect cannot move it
        if (mem_req_o && !out_q) begin
          addr_d = pc_q;
        end
        if (redirect_i) begin
          pc_d = redirect_pc_i;
          if (misaligned) begin
            state_d   = S_FAULT;
            out_d     = 1'b0;
            discard_d = 1'b0;
          end else if (mem_req_o && !mem_ready_i) begin
            out_d     = 1'b1;
            discard_d = 1'b1;
          end else if (mem_req_o) begin
            // Data returning alongside the redirect belongs to the old path
            out_d     = 1'b0;
            discard_d = 1'b0;
          end
        end else if (mem_req_o && mem_ready_i) begin
          out_d = 1'b0;
          if (discard_q) begin
            discard_d = 1'b0;
          end else begin
            insn_d  = mem_rdata_i;
            state_d = S_ISSUE;
          end
        end else if (mem_req_o) begin
          out_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (insn_ack_i) begin
          if (redirect_i) begin
            pc_d    = redirect_pc_i;
            state_d = misaligned ? S_FAULT : S_FETCH;
          end else begin
            pc_d    = pc_q + INC_W;
            state_d = S_FETCH;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Outputs; a started request is held until ready regardless of halt_i
  always_comb begin
    mem_req_o    = (state_q == S_FETCH) && run_q && (out_q || !halt_i);
    mem_addr_o   = out_q ? addr_q : pc_q;
    insn_o       = insn_q;
    pc_o         = pc_q;
    pc_inc_o     = pc_q + INC_W;
    insn_valid_o = (state_q == S_ISSUE);
    fault_o      = (state_q == S_FAULT);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios with a scoreboard.
// Stimulus pushes expected memory-handshake addresses and expected
// decode-handshake tuples into queues; negedge monitors pop and compare.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] insn_o;
  logic [31:0] pc_o;
  logic [31:0] pc_inc_o;
  logic        insn_valid_o;
  logic        insn_ack_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        halt_i = 1'b1;
  logic        fault_o;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0100), .INC(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rdata_i  (mem_rdata_i),
    .insn_o       (insn_o),
    .pc_o         (pc_o),
    .pc_inc_o     (pc_inc_o),
    .insn_valid_o (insn_valid_o),
    .insn_ack_i   (insn_ack_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .halt_i       (halt_i),
    .fault_o      (fault_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [31:0] insn;
  } iss_t;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_req_q[$];
  iss_t        exp_iss_q[$];
  int          mem_lat  = 0;
  int          wait_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_iss(input logic [31:0] pc, input logic [31:0] pc_inc, input logic [31:0] insn);
    iss_t e;
    e.pc     = pc;
    e.pc_inc = pc_inc;
    e.insn   = insn;
    exp_iss_q.push_back(e);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0300) return 32'h0050_0093;
    return 32'hA500_0000 | {8'h00, a[23:0]};
  endfunction

  // Memory model: ready after mem_lat waiting cycles of an asserted request
  always @(posedge clk) begin
    #2;
    if (mem_req_o) begin
      if (wait_cnt >= mem_lat) begin
        mem_ready_i = 1'b1;
        mem_rdata_i = mem_word(mem_addr_o);
        wait_cnt    = 0;
      end else begin
        mem_ready_i = 1'b0;
        wait_cnt    = wait_cnt + 1;
      end
    end else begin
      mem_ready_i = 1'b0;
      wait_cnt    = 0;
    end
  end

  // Memory-side monitor
  always @(negedge clk) begin
    if (reset_n && mem_req_o && mem_ready_i) begin
      if (exp_req_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL req_unexpected: got addr %h expected no request", mem_addr_o);
      end else begin
        check("req_addr", mem_addr_o, exp_req_q.pop_front());
      end
    end
  end

  // Decode-side monitor
  always @(negedge clk) begin
    iss_t e;
    if (reset_n && insn_valid_o && insn_ack_i) begin
      if (exp_iss_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL iss_unexpected: got pc %h insn %h expected no issue", pc_o, insn_o);
      end else begin
        e = exp_iss_q.pop_front();
        check("iss_pc", pc_o, e.pc);
        check("iss_pc_inc", pc_inc_o, e.pc_inc);
        check("iss_insn", insn_o, e.insn);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until both scoreboards empty, then stop new fetches
  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      tick();
      if (exp_req_q.size() == 0 && exp_iss_q.size() == 0) break;
    end
    halt_i = 1'b1;
    check("drain_req_left", exp_req_q.size(), 0);
    check("drain_iss_left", exp_iss_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pc", pc_o, 32'h0000_0100);
    check("rst_pc_inc", pc_inc_o, 32'h0000_0104);
    check("rst_insn", insn_o, 32'h0);
    check("rst_valid", insn_valid_o, 1'b0);
    check("rst_req", mem_req_o, 1'b0);
    check("rst_fault", fault_o, 1'b0);

    // Back-to-back sequential fetch with ready and ack tied high
    @(posedge clk); #1;
    exp_req_q.push_back(32'h0000_0100);
    exp_req_q.push_back(32'h0000_0104);
    exp_req_q.push_back(32'h0000_0108);
    push_iss(32'h0000_0100, 32'h0000_0104, 32'hA500_0100);
    push_iss(32'h0000_0104, 32'h0000_0108, 32'hA500_0104);
    push_iss(32'h0000_0108, 32'h0000_010C, 32'hA500_0108);
    halt_i     = 1'b0;
    insn_ack_i = 1'b1;
    mem_lat    = 0;
    reset_n    = 1'b1;
    drain(40);

    // Redirect while idle, then a 3-cycle memory stall
    insn_ack_i    = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0300;
    tick();
    redirect_i = 1'b0;
    mem_lat    = 3;
    halt_i     = 1'b0;
    exp_req_q.push_back(32'h0000_0300);
    push_iss(32'h0000_0300, 32'h0000_0304, 32'h0050_0093);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req", mem_req_o, 1'b1);
      check("stall_addr", mem_addr_o, 32'h0000_0300);
      check("stall_valid", insn_valid_o, 1'b0);
    end
    @(negedge clk);
    check("ready_addr", mem_addr_o, 32'h0000_0300);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("hold_valid", insn_valid_o, 1'b1);
      check("hold_insn", insn_o, 32'h0050_0093);
      check("hold_pc", pc_o, 32'h0000_0300);
    end
    @(posedge clk); #1;
    insn_ack_i = 1'b1;
    tick();

    // Redirect during an outstanding fetch: old data dropped
    insn_ack_i = 1'b0;
    exp_req_q.push_back(32'h0000_0304);
    exp_req_q.push_back(32'h0000_0200);
    push_iss(32'h0000_0200, 32'h0000_0204, 32'hA500_0200);
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    tick();
    redirect_i = 1'b0;
    mem_lat    = 0;
    insn_ack_i = 1'b1;
    @(negedge clk);
    check("discard_addr_held", mem_addr_o, 32'h0000_0304);
    check("discard_req_held", mem_req_o, 1'b1);
    drain(20);

    // Misaligned redirect on ack enters FAULT
    insn_ack_i = 1'b0;
    halt_i     = 1'b0;
    exp_req_q.push_back(32'h0000_0204);
    push_iss(32'h0000_0204, 32'h0000_0208, 32'hA500_0204);
    tick();
    insn_ack_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0202;
    tick();
    insn_ack_i = 1'b0;
    redirect_i = 1'b0;
    @(negedge clk);
    check("fault_set", fault_o, 1'b1);
    check("fault_pc", pc_o, 32'h0000_0202);
    check("fault_valid", insn_valid_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fault_no_req", mem_req_o, 1'b0);
      check("fault_sticky", fault_o, 1'b1);
    end
    @(posedge clk); #1;
    halt_i  = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst2_pc", pc_o, 32'h0000_0100);
    check("rst2_fault", fault_o, 1'b0);
    check("rst2_req", mem_req_o, 1'b0);
    check("rst2_insn", insn_o, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    // PC wrap at the top of the address space
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    halt_i     = 1'b0;
    insn_ack_i = 1'b1;
    exp_req_q.push_back(32'hFFFF_FFFC);
    exp_req_q.push_back(32'h0000_0000);
    push_iss(32'hFFFF_FFFC, 32'h0000_0000, 32'hA5FF_FFFC);
    push_iss(32'h0000_0000, 32'h0000_0004, 32'hA500_0000);
    drain(30);
    @(negedge clk);
    check("wrap_fault", fault_o, 1'b0);
    check("wrap_pc", pc_o, 32'h0000_0004);

    // halt_i raised during ISSUE blocks the next request until it drops
    @(posedge clk); #1;
    insn_ack_i = 1'b0;
    halt_i     = 1'b0;
    exp_req_q.push_back(32'h0000_0004);
    exp_req_q.push_back(32'h0000_0008);
    push_iss(32'h0000_0004, 32'h0000_0008, 32'hA500_0004);
    push_iss(32'h0000_0008, 32'h0000_000C, 32'hA500_0008);
    tick();
    halt_i     = 1'b1;
    insn_ack_i = 1'b1;
    tick();
    insn_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_no_req", mem_req_o, 1'b0);
    end
    @(posedge clk); #1;
    halt_i     = 1'b0;
    insn_ack_i = 1'b1;
    @(negedge clk);
    check("unhalt_req", mem_req_o, 1'b1);
    check("unhalt_addr", mem_addr_o, 32'h0000_0008);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
